// File: rtl/softmax_input_collector_pkg.sv
// Shared constants and types for the softmax input collector.
// Frame geometry defaults match the softMax classifier input.
package softmax_input_collector_pkg;

    localparam int SOFTMAX_IN_BIT_WIDTH = 4;
    localparam int SOFTMAX_NUM_CLASSES  = 10;
    localparam int SUM_IN_WIDTH         = 16;
    localparam int SUM_SHIFT            = 4;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } coll_state_e;

endpackage

// File: rtl/softmax_input_collector_quantizer.sv
// Combinational quantizer: signed neuron sum to saturated unsigned slot.
// Negative sums clamp to zero, large sums clamp to all-ones.
module sum_quantizer #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 4,
    parameter int SHIFT     = 4
) (
    input  logic signed [IN_WIDTH-1:0]  in_data,
    output logic        [OUT_WIDTH-1:0] q
);

    localparam int                MAX_I = (1 << OUT_WIDTH) - 1;
    localparam logic [IN_WIDTH-1:0] MAX_V = MAX_I[IN_WIDTH-1:0];

    logic [IN_WIDTH-1:0] sh;

    assign sh = in_data >>> SHIFT;

    // Full-width compare so large sums never wrap into small slot values.
    always_comb begin
        q = '0;
        if (in_data[IN_WIDTH-1]) begin
            q = '0;
        end else if (sh > MAX_V) begin
            q = MAX_V[OUT_WIDTH-1:0];
        end else begin
            q = sh[OUT_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/softmax_input_collector.sv
// Packs serial neuron sums into one quantized frame for the softMax block.
// A second frame may assemble while the previous one waits on out_ready.
module softmax_input_collector
    import softmax_input_collector_pkg::*;
#(
    parameter int NUM_CLASSES = SOFTMAX_NUM_CLASSES,
    parameter int IN_WIDTH    = SUM_IN_WIDTH,
    parameter int OUT_WIDTH   = SOFTMAX_IN_BIT_WIDTH,
    parameter int SHIFT       = SUM_SHIFT
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic signed [IN_WIDTH-1:0]       in_data,
    input  logic                             in_last,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [NUM_CLASSES*OUT_WIDTH-1:0] sum_out,
    output logic                             frame_error
);

    localparam int               IDX_W    = $clog2(NUM_CLASSES);
    localparam int               FRAME_W  = NUM_CLASSES * OUT_WIDTH;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

    coll_state_e          state;
    logic [IDX_W-1:0]     idx;
    logic [FRAME_W-1:0]   asm_q;
    logic [FRAME_W-1:0]   merged;
    logic [OUT_WIDTH-1:0] q;
    logic                 accept;
    logic                 slot_free;
    logic                 at_last;

    sum_quantizer #(
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .SHIFT     (SHIFT)
    ) u_quant (
        .in_data (in_data),
        .q       (q)
    );

    assign in_ready  = (state == FILL) && !reset;
    assign accept    = in_valid && in_ready;
    assign slot_free = !out_valid || out_ready;
    assign at_last   = (idx == LAST_IDX);

    // Assembly contents with the current beat dropped into its slot.
    always_comb begin
        merged = asm_q;
        for (int i = 0; i < NUM_CLASSES; i++) begin
            if (int'(idx) == i) begin
                merged[i*OUT_WIDTH +: OUT_WIDTH] = q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FILL;
            idx         <= '0;
            asm_q       <= '0;
            sum_out     <= '0;
            out_valid   <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            frame_error <= 1'b0;
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            unique case (state)
                FILL: begin
                    if (accept) begin
                        if (in_last && !at_last) begin
                            frame_error <= 1'b1;
                            idx         <= '0;
                        end else if (at_last) begin
                            frame_error <= !in_last;
                            if (slot_free) begin
                                sum_out   <= merged;
                                out_valid <= 1'b1;
                                idx       <= '0;
                            end else begin
                                asm_q <= merged;
                                state <= HOLD;
                            end
                        end else begin
                            asm_q <= merged;
                            idx   <= idx + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (slot_free) begin
                        sum_out   <= asm_q;
                        out_valid <= 1'b1;
                        idx       <= '0;
                        state     <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule
